// File: rtl/ro_pair_comparator.sv
// Ring-oscillator pair comparator: counts synchronized rising edges of two
// oscillator outputs over a programmable window and reports which was faster.
module ro_pair_comparator #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned WIN_W      = 16,
  parameter int unsigned SETTLE_CYC = 8
) (
  input  logic             d_clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIN_W-1:0] window_len,
  input  logic             ro_a_in,
  input  logic             ro_b_in,
  input  logic             resp_ack,
  output logic             ro_enable,
  output logic             busy,
  output logic             resp_valid,
  output logic             resp_bit,
  output logic             resp_tie,
  output logic [CNT_W-1:0] count_a,
  output logic [CNT_W-1:0] count_b
);

  localparam int unsigned     ST_W        = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [ST_W-1:0] SETTLE_LAST = ST_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  typedef enum logic [2:0] {IDLE, SETTLE, MEASURE, COMPARE, DONE} state_t;

  state_t state, state_next;

  // [0],[1]: two-flop synchronizer, [2]: history flop for edge detection
  logic [2:0]       sync_a, sync_b;
  logic             rise_a, rise_b;
  logic [WIN_W-1:0] win, meas_cnt, meas_last;
  logic [ST_W-1:0]  settle_cnt;
  logic             accept, settle_end, meas_end;

  assign rise_a     = sync_a[1] & ~sync_a[2];
  assign rise_b     = sync_b[1] & ~sync_b[2];
  assign accept     = (state == IDLE) && start;
  assign settle_end = (settle_cnt == SETTLE_LAST);
  // A zero window is stretched to a single counting cycle.
  assign meas_last  = (win == '0) ? '0 : win - WIN_W'(1);
  assign meas_end   = (meas_cnt == meas_last);

  always_ff @(posedge d_clk) begin
    if (reset) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= {sync_a[1:0], ro_a_in};
      sync_b <= {sync_b[1:0], ro_b_in};
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)      state_next = SETTLE;
      SETTLE:  if (settle_end) state_next = MEASURE;
      MEASURE: if (meas_end)   state_next = COMPARE;
      COMPARE:                 state_next = DONE;
      DONE:    if (resp_ack)   state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  always_comb begin
    ro_enable  = 1'b0;
    busy       = 1'b1;
    resp_valid = 1'b0;
    case (state)
      IDLE:             busy       = 1'b0;
      SETTLE, MEASURE:  ro_enable  = 1'b1;
      DONE:             resp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge d_clk) begin
    if (reset) begin
      state      <= IDLE;
      win        <= '0;
      settle_cnt <= '0;
      meas_cnt   <= '0;
      count_a    <= '0;
      count_b    <= '0;
      resp_bit   <= 1'b0;
      resp_tie   <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        win        <= window_len;
        settle_cnt <= '0;
        meas_cnt   <= '0;
        count_a    <= '0;
        count_b    <= '0;
      end
      if (state == SETTLE)
        settle_cnt <= settle_cnt + ST_W'(1);
      if (state == MEASURE) begin
        meas_cnt <= meas_cnt + WIN_W'(1);
        if (rise_a && (count_a != CNT_MAX))
          count_a <= count_a + CNT_W'(1);
        if (rise_b && (count_b != CNT_MAX))
          count_b <= count_b + CNT_W'(1);
      end
      if (state == COMPARE) begin
        resp_bit <= (count_a > count_b);
        resp_tie <= (count_a == count_b);
      end
    end
  end

endmodule

// File: tb/tb_ro_pair_comparator.sv
// Bench for ro_pair_comparator: a 16-bit and a 4-bit counter instance run in
// lockstep against an edge-history reference model.
module tb_ro_pair_comparator;

  localparam int S  = 8;
  localparam int HN = 4096;

  logic        d_clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        resp_ack = 1'b0;
  logic        ro_a = 1'b0;
  logic        ro_b = 1'b0;
  logic [15:0] window_len = '0;

  logic        ro_enable, busy, resp_valid, resp_bit, resp_tie;
  logic [15:0] count_a, count_b;
  logic        ro_enable_s, busy_s, resp_valid_s, resp_bit_s, resp_tie_s;
  logic [3:0]  count_a_s, count_b_s;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mode = 0;
  int half_a = 2;
  int half_b = 3;
  bit hist_a [HN];
  bit hist_b [HN];

  ro_pair_comparator #(.CNT_W(16), .WIN_W(16), .SETTLE_CYC(S)) dut (
    .d_clk(d_clk), .reset(reset), .start(start), .window_len(window_len),
    .ro_a_in(ro_a), .ro_b_in(ro_b), .resp_ack(resp_ack),
    .ro_enable(ro_enable), .busy(busy), .resp_valid(resp_valid),
    .resp_bit(resp_bit), .resp_tie(resp_tie), .count_a(count_a), .count_b(count_b));

  ro_pair_comparator #(.CNT_W(4), .WIN_W(16), .SETTLE_CYC(S)) dut_s (
    .d_clk(d_clk), .reset(reset), .start(start), .window_len(window_len),
    .ro_a_in(ro_a), .ro_b_in(ro_b), .resp_ack(resp_ack),
    .ro_enable(ro_enable_s), .busy(busy_s), .resp_valid(resp_valid_s),
    .resp_bit(resp_bit_s), .resp_tie(resp_tie_s), .count_a(count_a_s), .count_b(count_b_s));

  always #5 d_clk = ~d_clk;

  // Oscillator stand-ins: record the value each edge samples, then drive the next one.
  initial forever begin
    @(posedge d_clk);
    hist_a[cyc % HN] = ro_a;
    hist_b[cyc % HN] = ro_b;
    cyc = cyc + 1;
    #2;
    case (mode)
      0: begin ro_a = 1'b0; ro_b = 1'b0; end
      1: begin ro_a = ((cyc / half_a) % 2) == 1; ro_b = ((cyc / half_b) % 2) == 1; end
      default: begin ro_a = 1'($urandom_range(0, 1)); ro_b = 1'($urandom_range(0, 1)); end
    endcase
  end

  // An input rise sampled at edges n-1 -> n is seen by the counter at edge n+2;
  // counting edges are the W edges following the settle period.
  function automatic int model_count(input int a0, input int w, input bit use_b);
    int n = 0;
    int weff = (w == 0) ? 1 : w;
    for (int m = a0 + S + 1; m <= a0 + S + weff; m++) begin
      bit cur  = use_b ? hist_b[(m - 2) % HN] : hist_a[(m - 2) % HN];
      bit prev = use_b ? hist_b[(m - 3) % HN] : hist_a[(m - 3) % HN];
      if (cur && !prev) n++;
    end
    return n;
  endfunction

  task automatic launch(input int win, input bit poke, output int a0, output int k, output int en_cnt);
    int weff = (win == 0) ? 1 : win;
    @(posedge d_clk); #1;
    window_len = win[15:0];
    start = 1'b1;
    @(posedge d_clk); #1;
    start = 1'b0;
    a0 = cyc - 1;
    k = 1;
    en_cnt = 0;
    while (resp_valid !== 1'b1 && k < 3000) begin
      if (ro_enable === 1'b1) en_cnt++;
      if (poke && (k == 3 || k == S + 1 || k == S + weff + 1)) begin
        start = 1'b1; resp_ack = 1'b1; window_len = 16'd5;
      end
      @(posedge d_clk); #1;
      start = 1'b0;
      resp_ack = 1'b0;
      k++;
    end
  endtask

  task automatic do_ack();
    resp_ack = 1'b1;
    @(posedge d_clk); #1;
    resp_ack = 1'b0;
  endtask

  task automatic test_reset();
    mode = 2;
    reset = 1'b1;
    repeat (3) @(posedge d_clk);
    #1;
    checks++; if ({ro_enable, busy, resp_valid, resp_bit, resp_tie, count_a, count_b} !== '0) begin
      errors++; $display("FAIL reset_outputs got %b want 0", {ro_enable, busy, resp_valid, resp_bit, resp_tie, count_a, count_b}); end
    checks++; if ({ro_enable_s, busy_s, resp_valid_s, resp_bit_s, resp_tie_s, count_a_s, count_b_s} !== '0) begin
      errors++; $display("FAIL reset_outputs_s got %b want 0", {ro_enable_s, busy_s, resp_valid_s, resp_bit_s, resp_tie_s, count_a_s, count_b_s}); end
    reset = 1'b0;
    repeat (6) @(posedge d_clk);
    #1;
    checks++; if ({busy, ro_enable, count_a, count_b} !== '0) begin
      errors++; $display("FAIL idle_after_reset got %b want 0", {busy, ro_enable, count_a, count_b}); end
  endtask

  task automatic test_basic();
    int a0, k, en_cnt, ea, eb;
    mode = 1; half_a = 2; half_b = 3;
    launch(100, 0, a0, k, en_cnt);
    ea = model_count(a0, 100, 0); eb = model_count(a0, 100, 1);
    checks++; if (k !== S + 102) begin errors++; $display("FAIL basic_latency got %0d want %0d", k, S + 102); end
    checks++; if (en_cnt !== S + 100) begin errors++; $display("FAIL basic_enable_cycles got %0d want %0d", en_cnt, S + 100); end
    checks++; if (count_a !== ea || ea < 24 || ea > 26) begin errors++; $display("FAIL basic_count_a got %0d want %0d (25+-1)", count_a, ea); end
    checks++; if (count_b !== eb || eb < 16 || eb > 18) begin errors++; $display("FAIL basic_count_b got %0d want %0d (17+-1)", count_b, eb); end
    checks++; if ({resp_bit, resp_tie} !== 2'b10) begin errors++; $display("FAIL basic_resp got %b want 10", {resp_bit, resp_tie}); end
    checks++; if (count_a_s !== 4'd15 || count_b_s !== 4'd15 || {resp_bit_s, resp_tie_s} !== 2'b01) begin
      errors++; $display("FAIL basic_sat got a=%0d b=%0d bt=%b want a=15 b=15 bt=01", count_a_s, count_b_s, {resp_bit_s, resp_tie_s}); end
    do_ack();
    checks++; if ({resp_valid, busy} !== 2'b00) begin errors++; $display("FAIL basic_ack got %b want 00", {resp_valid, busy}); end
  endtask

  task automatic test_tie();
    int a0, k, en_cnt, ea, eb;
    mode = 1; half_a = 2; half_b = 2;
    launch(40, 0, a0, k, en_cnt);
    ea = model_count(a0, 40, 0); eb = model_count(a0, 40, 1);
    checks++; if (count_a !== ea || count_b !== eb || ea < 9 || ea > 11) begin
      errors++; $display("FAIL tie_counts got a=%0d b=%0d want a=%0d b=%0d", count_a, count_b, ea, eb); end
    checks++; if ({resp_bit, resp_tie} !== 2'b01) begin errors++; $display("FAIL tie_resp got %b want 01", {resp_bit, resp_tie}); end
    checks++; if (count_a_s !== 4'(ea) || {resp_bit_s, resp_tie_s} !== 2'b01) begin
      errors++; $display("FAIL tie_sat got a=%0d bt=%b want a=%0d bt=01", count_a_s, {resp_bit_s, resp_tie_s}, ea); end
    do_ack();
  endtask

  task automatic test_saturation();
    int a0, k, en_cnt, ea, eb, eb_s;
    mode = 1; half_a = 1; half_b = 4;
    launch(100, 0, a0, k, en_cnt);
    ea = model_count(a0, 100, 0); eb = model_count(a0, 100, 1);
    eb_s = (eb > 15) ? 15 : eb;
    checks++; if (count_a !== ea || ea <= 15) begin errors++; $display("FAIL sat_wide_count_a got %0d want %0d", count_a, ea); end
    checks++; if (count_a_s !== 4'd15) begin errors++; $display("FAIL sat_count_a got %0d want 15", count_a_s); end
    checks++; if (count_b_s !== 4'(eb_s) || resp_bit_s !== (eb_s < 15) || resp_tie_s !== (eb_s == 15)) begin
      errors++; $display("FAIL sat_b_resp got b=%0d bt=%b want b=%0d", count_b_s, {resp_bit_s, resp_tie_s}, eb_s); end
    do_ack();
  endtask

  task automatic test_zero_window();
    int a0, k, en_cnt, ea, eb;
    mode = 2;
    launch(0, 0, a0, k, en_cnt);
    ea = model_count(a0, 0, 0); eb = model_count(a0, 0, 1);
    checks++; if (k !== S + 3) begin errors++; $display("FAIL zero_latency got %0d want %0d", k, S + 3); end
    checks++; if (en_cnt !== S + 1) begin errors++; $display("FAIL zero_enable_cycles got %0d want %0d", en_cnt, S + 1); end
    checks++; if (count_a !== ea || count_b !== eb || ea > 1 || eb > 1) begin
      errors++; $display("FAIL zero_counts got a=%0d b=%0d want a=%0d b=%0d", count_a, count_b, ea, eb); end
    do_ack();
  endtask

  task automatic test_reset_mid_measure();
    bit seen = 1'b0;
    mode = 1; half_a = 2; half_b = 3;
    @(posedge d_clk); #1;
    window_len = 16'd100; start = 1'b1;
    @(posedge d_clk); #1;
    start = 1'b0;
    repeat (S + 19) @(posedge d_clk);
    #1;
    checks++; if ({busy, ro_enable} !== 2'b11 || count_a === 16'd0) begin
      errors++; $display("FAIL midrun_active got be=%b a=%0d want be=11 a>0", {busy, ro_enable}, count_a); end
    reset = 1'b1;
    @(posedge d_clk); #1;
    reset = 1'b0;
    checks++; if ({busy, ro_enable, resp_valid, count_a, count_b} !== '0) begin
      errors++; $display("FAIL midrun_reset got %b want 0", {busy, ro_enable, resp_valid, count_a, count_b}); end
    for (int i = 0; i < 200; i++) begin
      @(posedge d_clk); #1;
      if (resp_valid !== 1'b0 || busy !== 1'b0 || count_a !== 16'd0 || count_b !== 16'd0) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL midrun_quiet got activity=1 want 0"); end
  endtask

  task automatic test_handshake();
    int a0, k, en_cnt, ea, eb;
    logic [33:0] snap;
    bit moved = 1'b0;
    mode = 2;
    launch(30, 1, a0, k, en_cnt);
    ea = model_count(a0, 30, 0); eb = model_count(a0, 30, 1);
    checks++; if (k !== S + 32 || count_a !== ea || count_b !== eb) begin
      errors++; $display("FAIL hs_run got k=%0d a=%0d b=%0d want k=%0d a=%0d b=%0d", k, count_a, count_b, S + 32, ea, eb); end
    snap = {resp_bit, resp_tie, count_a, count_b};
    for (int i = 0; i < 50; i++) begin
      @(posedge d_clk); #1;
      checks++; if (resp_valid !== 1'b1 || {resp_bit, resp_tie, count_a, count_b} !== snap) begin
        errors++; $display("FAIL hs_hold cycle %0d got v=%b d=%h want v=1 d=%h", i, resp_valid, {resp_bit, resp_tie, count_a, count_b}, snap); end
    end
    start = 1'b1; resp_ack = 1'b1; window_len = 16'd10;
    @(posedge d_clk); #1;
    start = 1'b0; resp_ack = 1'b0;
    checks++; if ({resp_valid, busy} !== 2'b00) begin errors++; $display("FAIL hs_ack_start got vb=%b want 00", {resp_valid, busy}); end
    for (int i = 0; i < 20; i++) begin
      @(posedge d_clk); #1;
      if (busy !== 1'b0 || ro_enable !== 1'b0 || {count_a, count_b} !== snap[31:0]) moved = 1'b1;
    end
    checks++; if (moved) begin errors++; $display("FAIL hs_no_new_run got activity=1 want 0"); end
  endtask

  task automatic test_random();
    int a0, k, en_cnt, ea, eb, ea_s, eb_s, win, weff;
    bit poke;
    for (int it = 0; it < 10; it++) begin
      mode = $urandom_range(1, 2); half_a = $urandom_range(1, 5); half_b = $urandom_range(1, 5);
      win = $urandom_range(0, 60); weff = (win == 0) ? 1 : win;
      poke = 1'($urandom_range(0, 1));
      launch(win, poke, a0, k, en_cnt);
      ea = model_count(a0, win, 0); eb = model_count(a0, win, 1);
      ea_s = (ea > 15) ? 15 : ea; eb_s = (eb > 15) ? 15 : eb;
      checks++; if (k !== S + weff + 2 || en_cnt !== S + weff) begin
        errors++; $display("FAIL rand%0d_timing got k=%0d en=%0d want k=%0d en=%0d", it, k, en_cnt, S + weff + 2, S + weff); end
      checks++; if (count_a !== ea || count_b !== eb || resp_bit !== (ea > eb) || resp_tie !== (ea == eb)) begin
        errors++; $display("FAIL rand%0d_result got a=%0d b=%0d bt=%b want a=%0d b=%0d", it, count_a, count_b, {resp_bit, resp_tie}, ea, eb); end
      checks++; if (count_a_s !== 4'(ea_s) || count_b_s !== 4'(eb_s) || resp_bit_s !== (ea_s > eb_s) || resp_tie_s !== (ea_s == eb_s)) begin
        errors++; $display("FAIL rand%0d_sat got a=%0d b=%0d bt=%b want a=%0d b=%0d", it, count_a_s, count_b_s, {resp_bit_s, resp_tie_s}, ea_s, eb_s); end
      repeat ($urandom_range(0, 4)) @(posedge d_clk);
      #1;
      do_ack();
      checks++; if ({resp_valid, busy, resp_valid_s} !== 3'b000) begin
        errors++; $display("FAIL rand%0d_ack got %b want 000", it, {resp_valid, busy, resp_valid_s}); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie();
    test_saturation();
    test_zero_window();
    test_reset_mid_measure();
    test_handshake();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
